key_sender: RTL and testbench

- Transmit-side counterpart of the push-button packet entry path.
- Takes 4-bit packets {dest[1:0], payload[1:0]} from a host-side valid/ready interface and queues them.
- Replays each packet as the button-level waveform the packet receiver expects: start held low, then four timed active-low presses on key0/key1, MSB first.
- Used as a board-level stimulus source and as the bench driver for the receiver; drives receiver inputs start/key0/key1 directly.

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_pkt_queue.sv | 64 ++++++
 rtl/key_sender.sv | 161 ++++++++++++++++
 tb/tb_key_sender.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key_sender packet-to-button replay path.
`timescale 1ns/1ps
package key_pkg;

  // Packet layout: {dest[1:0], payload[1:0]}
  localparam int PKT_W    = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 2;
  localparam int PAY_MSB  = 1;
  localparam int PAY_LSB  = 0;

  // Buttons and the start strobe are active-low; this is their released level.
  localparam logic KEY_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PRESS,
    ST_RELEASE,
    ST_GAP
  } state_t;

  // Key levels for one bit, returned as {key1, key0}. Exactly one key is low,
  // so the receiver never sees both buttons pressed together.
  function automatic logic [1:0] press_keys(input logic bit_val);
    return bit_val ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/key_pkt_queue.sv
// Synchronous FIFO holding packets waiting to be replayed as key presses.
// Read data is first-word fall-through: rd_data shows the head entry whenever
// the queue is non-empty.
`timescale 1ns/1ps
module key_pkt_queue
  import key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PKT_W-1:0]           wr_data,
  output logic [PKT_W-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  // A push into a full queue is refused even if a pop happens the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; entries are only read after
  // being written, and leaving reset off lets the storage map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/key_sender.sv
// Replays queued 4-bit packets as the push-button waveform the packet receiver
// expects: a start strobe held low, then four timed active-low presses on
// key0 ('0' bit) or key1 ('1' bit), most significant bit first.
`timescale 1ns/1ps
module key_sender
  import key_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int START_CYCLES   = 2,
  parameter int PRESS_CYCLES   = 4,
  parameter int RELEASE_CYCLES = 4,
  parameter int GAP_CYCLES     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             pkt_ready,
  input  logic             hold,
  output logic             start,
  output logic             key0,
  output logic             key1,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sent_count
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] QD_C = CNT_W'(QUEUE_DEPTH);

  // Timer reload values. Every phase lasts "load + 1" cycles; a zero-length
  // gap still costs one cycle in GAP.
  localparam int START_LD_I = START_CYCLES - 1;
  localparam int PRESS_LD_I = PRESS_CYCLES - 1;
  localparam int REL_LD_I   = RELEASE_CYCLES - 1;
  localparam int GAP_LD_I   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TM_MAX_A   = (START_LD_I > PRESS_LD_I) ? START_LD_I : PRESS_LD_I;
  localparam int TM_MAX_B   = (REL_LD_I > GAP_LD_I) ? REL_LD_I : GAP_LD_I;
  localparam int TM_MAX     = (TM_MAX_A > TM_MAX_B) ? TM_MAX_A : TM_MAX_B;
  localparam int TM_W       = (TM_MAX > 0) ? $clog2(TM_MAX + 1) : 1;

  localparam logic [TM_W-1:0] START_LD = TM_W'(START_LD_I);
  localparam logic [TM_W-1:0] PRESS_LD = TM_W'(PRESS_LD_I);
  localparam logic [TM_W-1:0] REL_LD   = TM_W'(REL_LD_I);
  localparam logic [TM_W-1:0] GAP_LD   = TM_W'(GAP_LD_I);

  state_t           state;
  logic [TM_W-1:0]  tm;
  logic [1:0]       bi;
  logic [1:0]       bi_next;
  logic [PKT_W-1:0] sr;

  logic [PKT_W-1:0] q_data;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic             q_push;
  logic             q_pop;

  // Readiness comes from the registered occupancy, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign pkt_ready = (q_count < QD_C);
  assign q_push    = pkt_valid & ~q_full;
  // hold only gates the launch of a new packet from IDLE.
  assign q_pop     = (state == ST_IDLE) & ~q_empty & ~hold;
  assign bi_next   = bi - 2'd1;

  key_pkt_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (q_push),
    .pop     (q_pop),
    .wr_data (pkt_data),
    .rd_data (q_data),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Packet sequencer: timers, bit index and all registered button outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tm         <= '0;
      bi         <= '0;
      sr         <= '0;
      start      <= KEY_IDLE;
      key0       <= KEY_IDLE;
      key1       <= KEY_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (q_pop) begin
            sr    <= q_data;
            bi    <= 2'd3;
            tm    <= START_LD;
            start <= 1'b0;
            busy  <= 1'b1;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tm == '0) begin
            start        <= KEY_IDLE;
            tm           <= PRESS_LD;
            {key1, key0} <= press_keys(sr[bi]);
            state        <= ST_PRESS;
          end else begin
            tm <= tm - TM_W'(1);
          end
        end
        ST_PRESS: begin
          if (tm == '0) begin
            key0  <= KEY_IDLE;
            key1  <= KEY_IDLE;
            tm    <= REL_LD;
            state <= ST_RELEASE;
          end else begin
            tm <= tm - TM_W'(1);
          end
        end
        ST_RELEASE: begin
          if (tm == '0) begin
            if (bi != 2'd0) begin
              bi           <= bi_next;
              tm           <= PRESS_LD;
              {key1, key0} <= press_keys(sr[bi_next]);
              state        <= ST_PRESS;
            end else begin
              tm    <= GAP_LD;
              state <= ST_GAP;
            end
          end else begin
            tm <= tm - TM_W'(1);
          end
        end
        ST_GAP: begin
          if (tm == '0) begin
            done       <= 1'b1;
            sent_count <= sent_count + 8'd1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            tm <= tm - TM_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sender.sv
// Bench for key_sender: stimulus pushes packets and records them in an
// expected queue; an independent monitor decodes the start/key waveform back
// into packets and phase lengths and compares them against that queue.
`timescale 1ns/1ps
module tb_key_sender;
  import key_pkg::*;

  localparam int QD = 4;
  localparam int SC = 2;
  localparam int PC = 4;
  localparam int RC = 4;
  localparam int GC = 8;
  localparam int GAP_EFF = (GC > 0) ? GC : 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [3:0] pkt_data = 4'h0;
  logic       hold = 1'b0;
  logic       pkt_ready, start, key0, key1, busy, done;
  logic [7:0] sent_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  int model_sent = 0;
  int mon_phase = 0;
  int mon_bit = 0;

  always #5 clk = ~clk;

  key_sender #(
    .QUEUE_DEPTH    (QD),
    .START_CYCLES   (SC),
    .PRESS_CYCLES   (PC),
    .RELEASE_CYCLES (RC),
    .GAP_CYCLES     (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_ready  (pkt_ready),
    .hold       (hold),
    .start      (start),
    .key0       (key0),
    .key1       (key1),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Waveform decoder: rebuilds each packet from the button activity.
  initial begin : monitor
    int slen, plen, rlen, key_id;
    logic [3:0] cur;
    slen = 0; plen = 0; rlen = 0; key_id = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_phase = 0;
        exp_q.delete();
        model_sent = 0;
      end else begin
        check("keys_exclusive", key0 | key1, 1);
        if (mon_phase == 0) begin
          check("idle_done", done, 0);
          check("idle_keys", {key1, key0}, 2'b11);
          if (start == 1'b0) begin
            check("start_expected", exp_q.size() > 0, 1);
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            slen = 1;
            mon_bit = 3;
            mon_phase = 1;
            check("busy_start", busy, 1);
          end else begin
            check("busy_idle", busy, 0);
          end
        end else if (mon_phase == 3) begin
          check("release_start_hi", start, 1);
          if (!key0 || !key1) begin
            check("release_len", rlen, RC);
            check("extra_press", mon_bit > 0, 1);
            mon_bit--;
            mon_phase = 2;
            plen = 1;
            key_id = (key1 == 1'b0) ? 1 : 0;
            check("busy_press", busy, 1);
          end else if (done) begin
            check("release_gap_len", rlen, RC + GAP_EFF);
            check("last_bit", mon_bit, 0);
            model_sent++;
            check("sent_count", sent_count, model_sent % 256);
            check("busy_done", busy, 0);
            mon_phase = 0;
          end else begin
            rlen++;
            check("busy_release", busy, 1);
          end
        end else begin
          if (mon_phase == 1) begin
            check("busy_start", busy, 1);
            if (start == 1'b0) begin
              check("start_keys_hi", {key1, key0}, 2'b11);
              slen++;
            end else begin
              check("start_len", slen, SC);
              mon_phase = 2;
              plen = 0;
            end
          end
          if (mon_phase == 2) begin
            check("press_start_hi", start, 1);
            check("busy_press", busy, 1);
            if (!key0 || !key1) begin
              if (plen == 0) key_id = (key1 == 1'b0) ? 1 : 0;
              else check("press_key_stable", (key1 == 1'b0) ? 1 : 0, key_id);
              plen++;
            end else begin
              check("press_len", plen, PC);
              check("press_key", key_id, cur[mon_bit]);
              mon_phase = 3;
              rlen = 1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input logic [3:0] d);
    int guard = 0;
    pkt_valid = 1'b1;
    pkt_data  = d;
    while (pkt_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (pkt_ready !== 1'b1) begin
      check("push_ready_timeout", pkt_ready, 1);
      pkt_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
      @(negedge clk);
      pkt_valid = 1'b0;
    end
  endtask

  task automatic wait_sent(input int n, input int budget);
    int c = 0;
    while (model_sent < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_sent", model_sent, n);
  endtask

  task automatic wait_press(input int bit_idx, input int budget);
    int c = 0;
    while (!(mon_phase == 2 && mon_bit == bit_idx) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("reach_press", mon_bit, bit_idx);
  endtask

  initial begin : stimulus
    logic [3:0] b2b[4];
    logic [3:0] d5;
    int lows;
    b2b[0] = 4'h0; b2b[1] = 4'hF; b2b[2] = 4'h9; b2b[3] = 4'h5;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start", start, 1);
    check("rst_key0", key0, 1);
    check("rst_key1", key1, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_count, 0);
    check("rst_ready", pkt_ready, 1);
    rst = 1'b0;

    // Single packet 0110 and launch latency.
    @(negedge clk);
    pkt_valid = 1'b1;
    pkt_data  = 4'h6;
    @(posedge clk);
    exp_q.push_back(4'h6);
    @(negedge clk);
    pkt_valid = 1'b0;
    check("lat_start_hi", start, 1);
    @(negedge clk);
    check("lat_start_lo", start, 0);
    wait_sent(1, 200);
    check("sent_one", sent_count, 1);

    // Back-to-back packets.
    for (int i = 0; i < 4; i++) begin
      check("ready_b2b", pkt_ready, 1);
      push_pkt(b2b[i]);
    end
    wait_sent(5, 4 * 60);
    check("sent_five", sent_count, 5);

    // Hold fills the queue; release launches and frees a slot.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_pkt(4'($urandom_range(0, 15)));
    check("ready_full", pkt_ready, 0);
    check("busy_on_hold", busy, 0);
    d5 = 4'($urandom_range(0, 15));
    pkt_valid = 1'b1;
    pkt_data  = d5;
    hold      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_release_start", start, 0);
    check("ready_after_pop", pkt_ready, 1);
    @(posedge clk);
    exp_q.push_back(d5);
    @(negedge clk);
    pkt_valid = 1'b0;
    wait_sent(10, 5 * 60);

    // Hold raised mid-packet: packet finishes, nothing new starts.
    push_pkt(4'hA);
    wait_press(1, 200);
    hold = 1'b1;
    push_pkt(4'h1);
    wait_sent(11, 200);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (start == 1'b0) lows++;
    end
    check("no_start_on_hold", lows, 0);
    hold = 1'b0;
    wait_sent(12, 200);

    // Randomized traffic with occasional hold windows.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        hold = 1'b1;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        hold = 1'b0;
      end
      push_pkt(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_sent(42, 30 * 60 + 200);

    // Reset during the press of bit 2 aborts the packet.
    push_pkt(4'($urandom_range(0, 15)));
    wait_press(2, 200);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_key0", key0, 1);
    check("abort_key1", key1, 1);
    check("abort_start", start, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", pkt_ready, 1);
    check("abort_sent", sent_count, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (done == 1'b1 || start == 1'b0) lows++;
    end
    check("abort_quiet", lows, 0);

    // 256 packets of 0011: counter wraps.
    for (int i = 0; i < 256; i++) push_pkt(4'h3);
    wait_sent(256, 256 * 50);
    check("sent_wrap", sent_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
